div_share_arbiter: RTL and testbench
====================================

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; parameters (name, default, meaning): NUM_REQ, 4, number of requesters; DATA_W, 16, operand width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  NUM_REQ  per-requester division request; held high with stable operands until acknowledged.
REQ-005 req_dividend  input  NUM_REQ x DATA_W  per-requester dividend.
REQ-006 req_divisor  input  NUM_REQ x DATA_W  per-requester divisor.
REQ-007 req_ack  output  NUM_REQ  one-cycle pulse: operands of that requester captured.
REQ-008 rsp_valid  output  1  one-cycle pulse: result on rsp_* is valid.
REQ-009 rsp_id  output  log2(NUM_REQ)  index of requester owning the result.
REQ-010 rsp_quotient, rsp_remainder  output  DATA_W each  result.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 div_start  output  1  one-cycle start pulse to the shared restoring divider.
REQ-013 div_dividend, div_divisor  output  DATA_W each  operands to the divider, stable from div_start until div_valid.
REQ-014 div_valid  input  1  divider done, results valid this cycle.
REQ-015 div_quotient, div_remainder  input  DATA_W each  divider results.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req bit is high, SHALL select one winner round-robin, latch its operands, pulse req_ack[winner] in the same cycle, and record rsp_id.
REQ-018 Round-robin: search starts at pointer p, increasing index with wrap; pointer SHALL become winner+1 (mod NUM_REQ) on each grant; reset value of p is 0.
REQ-019 IDLE -> ISSUE when the latched divisor is nonzero; IDLE -> RESP when it is zero.
REQ-020 Divide-by-zero SHALL bypass the divider: rsp_quotient = 0, rsp_remainder = dividend; div_start not asserted.
REQ-021 ISSUE: div_start high for exactly one cycle, then -> WAIT.
REQ-022 WAIT: on div_valid SHALL latch div_quotient/div_remainder and -> RESP; no timeout.
REQ-023 RESP: rsp_valid high for exactly one cycle with rsp_id/rsp_quotient/rsp_remainder, then -> IDLE.
REQ-024 rsp_id, rsp_quotient, rsp_remainder SHALL hold their last values until the next RESP.
REQ-025 div_valid SHALL be ignored outside WAIT.
REQ-026 req bits arriving while busy SHALL wait; no request is lost while held high; at most one grant per transaction.
REQ-027 A requester dropping req before ack SHALL simply not be granted; no effect after ack.
REQ-028 Latency: nonzero divisor, grant cycle to rsp_valid = 2 + divider latency cycles; zero divisor = 1 cycle; a new grant is possible the cycle after RESP.
REQ-029 Operands SHALL pass to the divider unmodified (unsigned, DATA_W bits); no width extension in this block.

Reset
REQ-030 On rst high at a clock edge, regardless of state, the FSM SHALL enter IDLE and all outputs SHALL be 0, pointer 0, latched operands/results 0.
REQ-031 Reset mid-transaction SHALL abort it with no rsp_valid; any subsequent div_valid from the divider SHALL be ignored.

Structure
REQ-032 A shared package div_pkg SHALL hold NUM_REQ, DATA_W defaults and the state enum type.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant, index, any).

Verification
REQ-034 req[0] with 25/3 -> req_ack[0] one pulse, one div_start, rsp_valid with rsp_id 0, quotient 8, remainder 1.
REQ-035 req[2] with 1234/0 -> rsp_valid exactly 1 cycle after ack, quotient 0, remainder 1234, no div_start.
REQ-036 All four req high from reset with 100/10, 50/7, 12345/123, 65535/1 -> grants in order 0,1,2,3; results 10/0, 7/1, 100/45, 65535/0 with matching rsp_id.
REQ-037 req[3] served, then req[1] and req[3] raised together -> req[1] granted first (pointer at 0 wraps to 1 before 3).
REQ-038 rst asserted during WAIT, then div_valid pulsed -> no rsp_valid, busy 0, all outputs 0; next request 50/7 completes normally.
REQ-039 Spurious div_valid in IDLE -> no state change, no rsp_valid.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared defaults and FSM state type for the divider share arbiter
package div_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at pointer, wrapping upward
module rr_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               any
);
    int k;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(pointer) + i) % NUM_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                index    = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one restoring divider among requesters
module div_share_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_dividend,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic                            rsp_valid,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [DATA_W-1:0]               rsp_quotient,
    output logic [DATA_W-1:0]               rsp_remainder,
    output logic                            busy,
    output logic                            div_start,
    output logic [DATA_W-1:0]               div_dividend,
    output logic [DATA_W-1:0]               div_divisor,
    input  logic                            div_valid,
    input  logic [DATA_W-1:0]               div_quotient,
    input  logic [DATA_W-1:0]               div_remainder
);
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     cur_id_q;
    logic [DATA_W-1:0]   dividend_q, divisor_q;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_index;
    logic                arb_any;
    logic                sel_zero;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req),
        .pointer (ptr_q),
        .grant   (arb_grant),
        .index   (arb_index),
        .any     (arb_any)
    );

    assign sel_zero     = (req_divisor[arb_index] == '0);
    assign busy         = (state_q != IDLE);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    always_comb begin
        state_d   = state_q;
        req_ack   = '0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // ack is gated by rst so no grant is signalled while reset is held
                if (arb_any && !rst) begin
                    req_ack = arb_grant;
                    state_d = sel_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_valid) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cur_id_q      <= '0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        ptr_q      <= (int'(arb_index) == NUM_REQ - 1) ? '0 : arb_index + ID_W'(1);
                        cur_id_q   <= arb_index;
                        dividend_q <= req_dividend[arb_index];
                        divisor_q  <= req_divisor[arb_index];
                        // divide-by-zero result is published directly on entry to RESP
                        if (sel_zero) begin
                            rsp_id        <= arb_index;
                            rsp_quotient  <= '0;
                            rsp_remainder <= req_dividend[arb_index];
                        end
                    end
                end
                WAIT: begin
                    if (div_valid) begin
                        rsp_id        <= cur_id_q;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - scoreboard bench for div_share_arbiter with a behavioural divider
module tb_div_share_arbiter;
    localparam int DIV_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [3:0][15:0]  req_dividend, req_divisor;
    logic [3:0]        req_ack;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_quotient, rsp_remainder;
    logic              busy, div_start;
    logic [15:0]       div_dividend, div_divisor;
    logic              div_valid;
    logic [15:0]       div_quotient, div_remainder;

    div_share_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid(div_valid), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // behavioural divider: result valid DIV_LAT cycles after the start cycle; not reset
    logic        mvalid = 1'b0, spurious = 1'b0;
    logic [15:0] ma, mb;
    int          mcnt = 0;
    assign div_valid = mvalid | spurious;
    always @(negedge clk) begin
        mvalid = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                mvalid        = 1'b1;
                div_quotient  = (mb == 0) ? 16'hFFFF : ma / mb;
                div_remainder = (mb == 0) ? ma : ma % mb;
            end
        end
        if (div_start) begin
            ma = div_dividend; mb = div_divisor; mcnt = DIV_LAT;
        end
    end

    typedef struct { int id; logic [15:0] a, b, q, r; } vec_t;
    typedef struct { int id; logic [15:0] q, r; bit zero; int gcyc; } sb_t;

    vec_t        tbl[4];
    sb_t         sb[$];
    int          grant_log[$];
    logic [15:0] op_a[4], op_b[4], exp_q[4], exp_r[4];
    logic [15:0] last_a, last_b;
    logic [3:0]  ack_seen;
    int checks = 0, errors = 0;
    int cyc = 0, ack_cnt = 0, start_cnt = 0, rsp_cnt = 0;
    int base_rsp, base_start, base_ack, n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        sb_t e;
        ack_seen = req_ack;
        if (req_ack != 4'b0) begin
            int id = 0;
            ack_cnt++;
            check("ack_onehot", 64'($onehot(req_ack)), 64'd1);
            for (int i = 0; i < 4; i++) if (req_ack[i]) id = i;
            grant_log.push_back(id);
            last_a = op_a[id]; last_b = op_b[id];
            sb.push_back('{id: id, q: exp_q[id], r: exp_r[id], zero: (op_b[id] == 0), gcyc: cyc});
        end
        if (div_start) begin
            start_cnt++;
            check("div_operands", {div_dividend, div_divisor}, {last_a, last_b});
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                check("rsp_remainder", 64'(rsp_remainder), 64'(e.r));
                check("latency", 64'(cyc - e.gcyc), e.zero ? 64'd1 : 64'(2 + DIV_LAT));
            end
        end
    endtask

    // sample at negedge; requesters drop req just after the edge that captured their ack
    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        req = req & ~ack_seen;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] r);
        op_a[id] = a; op_b[id] = b; exp_q[id] = q; exp_r[id] = r;
        req_dividend[id] = a; req_divisor[id] = b;
        req[id] = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        n = 0;
        while (rsp_cnt < target && n < budget) begin
            step();
            n++;
        end
        if (rsp_cnt < target) check("wait_rsp_timeout", 64'(rsp_cnt), 64'(target));
    endtask

    initial begin
        tbl[0] = '{id: 0, a: 16'd100,   b: 16'd10,  q: 16'd10,    r: 16'd0};
        tbl[1] = '{id: 1, a: 16'd50,    b: 16'd7,   q: 16'd7,     r: 16'd1};
        tbl[2] = '{id: 2, a: 16'd12345, b: 16'd123, q: 16'd100,   r: 16'd45};
        tbl[3] = '{id: 3, a: 16'd65535, b: 16'd1,   q: 16'd65535, r: 16'd0};
        rst = 1'b1; req = '0; req_dividend = '0; req_divisor = '0;
        div_quotient = '0; div_remainder = '0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0; op_b[i] = '0; exp_q[i] = '0; exp_r[i] = '0;
        end
        last_a = '0; last_b = '0;

        // all four requesters raised while reset is held
        for (int i = 0; i < 4; i++) set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
        step(); step();
        check("reset_req_ack", 64'(req_ack), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_div_start", 64'(div_start), 64'd0);
        check("reset_rsp", {rsp_id, rsp_quotient, rsp_remainder}, 64'd0);
        check("reset_div_ops", {div_dividend, div_divisor}, 64'd0);
        rst = 1'b0;
        wait_rsp(4, 200);
        for (int i = 0; i < 4; i++)
            check("grant_order", 64'(grant_log.size() > i ? grant_log[i] : -1), 64'(tbl[i].id));

        // single nonzero division
        base_start = start_cnt; base_ack = ack_cnt;
        set_req(0, 16'd25, 16'd3, 16'd8, 16'd1);
        wait_rsp(rsp_cnt + 1, 50);
        check("single_starts", 64'(start_cnt - base_start), 64'd1);
        check("single_acks", 64'(ack_cnt - base_ack), 64'd1);

        // divide by zero bypasses the divider
        base_start = start_cnt;
        set_req(2, 16'd1234, 16'd0, 16'd0, 16'd1234);
        wait_rsp(rsp_cnt + 1, 50);
        check("zero_starts", 64'(start_cnt - base_start), 64'd0);

        // pointer wraps to 0, so requester 1 beats requester 3
        set_req(3, 16'd7, 16'd2, 16'd3, 16'd1);
        wait_rsp(rsp_cnt + 1, 50);
        grant_log.delete();
        set_req(1, 16'd9, 16'd4, 16'd2, 16'd1);
        set_req(3, 16'd20, 16'd6, 16'd3, 16'd2);
        wait_rsp(rsp_cnt + 2, 100);
        check("wrap_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);
        check("wrap_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd3);

        // spurious div_valid while idle
        base_rsp = rsp_cnt;
        spurious = 1'b1; step(); spurious = 1'b0; step(); step();
        check("spurious_busy", 64'(busy), 64'd0);
        check("spurious_rsp", 64'(rsp_cnt), 64'(base_rsp));

        // reset during WAIT, then the stale div_valid must be ignored
        base_start = start_cnt;
        set_req(0, 16'd50, 16'd7, 16'd7, 16'd1);
        n = 0;
        while (start_cnt == base_start && n < 20) begin step(); n++; end
        check("abort_reached_wait", 64'(busy && start_cnt > base_start), 64'd1);
        base_rsp = rsp_cnt;
        rst = 1'b1; step(); rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) step();
        check("abort_no_rsp", 64'(rsp_cnt), 64'(base_rsp));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rsp_regs", {rsp_id, rsp_quotient, rsp_remainder}, 64'd0);
        check("abort_div_ops", {div_dividend, div_divisor}, 64'd0);

        base_start = start_cnt;
        set_req(0, 16'd50, 16'd7, 16'd7, 16'd1);
        wait_rsp(rsp_cnt + 1, 50);
        check("after_abort_starts", 64'(start_cnt - base_start), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
